// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: data-hazard detection and operand-forward select generation
// for a five-stage in-order pipeline.
//
// Shadow copies of the execute (E) and memory (M) stage bookkeeping let the
// block find in-flight producers of the ID instruction's source registers.
//
// Configuration macro: HAZARD_FORWARDING_EN
//   defined   : forward from MEM/WB; stall only on load-use (one cycle).
//   undefined : no forwarding (muxes tied to 0); stall while any producer
//               of a source is in E or M.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   id_valid            ID holds a real instruction
//   id_src1, id_src2    ID source register numbers
//   id_src2_is_reg      id_src2 is a register operand (not an immediate)
//   id_dest             ID destination register
//   id_wb_en            ID instruction writes id_dest
//   id_mem_read         ID instruction is a load
//   flush               branch taken: squash the ID instruction
//   src1_mux, src2_mux  registered execute-stage operand selects
//                       (0 = regfile, 1 = MEM ALU result, 2 = WB value)
//   stall               combinational: freeze PC and IF/ID
//   stall_cnt           saturating count of stall cycles
module hazard_fwd_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_src1,
    input  logic [4:0]  id_src2,
    input  logic        id_src2_is_reg,
    input  logic [4:0]  id_dest,
    input  logic        id_wb_en,
    input  logic        id_mem_read,
    input  logic        flush,
    output logic [1:0]  src1_mux,
    output logic [1:0]  src2_mux,
    output logic        stall,
    output logic [15:0] stall_cnt
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 16;

    localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_read;
    } shadow_t;

    localparam shadow_t BUBBLE = '0;

    shadow_t e_q;
    shadow_t m_q;
    shadow_t e_d;

    logic             src1_e;
    logic             src2_e;
    logic             src1_m;
    logic             src2_m;
    logic             insert_bubble;
    logic [SEL_W-1:0] sel1;
    logic [SEL_W-1:0] sel2;

    // A shadow produces a source if it is a live writer of that non-zero register.
    function automatic logic produces(input shadow_t sh, input logic [REG_W-1:0] src);
        return sh.valid && sh.wb_en && (sh.dest == src) && (src != '0);
    endfunction

    // Source matches against both shadows; src2 ignored when it is an immediate.
    always_comb begin
        src1_e = produces(e_q, id_src1);
        src1_m = produces(m_q, id_src1);
        src2_e = id_src2_is_reg && produces(e_q, id_src2);
        src2_m = id_src2_is_reg && produces(m_q, id_src2);
    end

`ifdef HAZARD_FORWARDING_EN
    // Only a load in E cannot be forwarded in time; newest producer (E) wins.
    always_comb begin
        stall = id_valid && !flush && e_q.mem_read && (src1_e || src2_e);
        sel1  = src1_e ? SEL_MEM : (src1_m ? SEL_WB : SEL_RF);
        sel2  = src2_e ? SEL_MEM : (src2_m ? SEL_WB : SEL_RF);
    end
`else
    // Without forwarding, wait until every producer has reached WB.
    always_comb begin
        stall = id_valid && !flush && (src1_e || src2_e || src1_m || src2_m);
        sel1  = SEL_RF;
        sel2  = SEL_RF;
    end
`endif

    // Next E shadow: the ID instruction, or a bubble if it does not advance.
    always_comb begin
        insert_bubble = stall || flush || !id_valid;
        e_d           = BUBBLE;
        if (!insert_bubble) begin
            e_d.valid    = 1'b1;
            e_d.dest     = id_dest;
            e_d.wb_en    = id_wb_en;
            e_d.mem_read = id_mem_read;
        end
    end

    // Shadow advance, registered selects and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q       <= BUBBLE;
            m_q       <= BUBBLE;
            src1_mux  <= SEL_RF;
            src2_mux  <= SEL_RF;
            stall_cnt <= '0;
        end else begin
            m_q      <= e_q;
            e_q      <= e_d;
            src1_mux <= insert_bubble ? SEL_RF : sel1;
            src2_mux <= insert_bubble ? SEL_RF : sel2;
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
